// File: rtl/dmem_access_ctrl.sv
// dmem_access_ctrl: sequences the data-memory access of the instruction in EX/MEM.
// Holds the request until mem_done, stalls the pipeline meanwhile, aborts hung
// or illegal accesses into a sticky error state.
// Optional build macro: DMEM_PERF_CNT_EN adds a saturating stall-cycle counter port.
module dmem_access_ctrl #(
    parameter int unsigned TIMEOUT = 64,
    parameter int unsigned CNT_W   = 7
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        EXMEM_IDEX_MemRead,
    input  logic        EXMEM_IDEX_MemWrite,
    input  logic        EXMEM_IDEX_HALT,
    input  logic [15:0] EXMEM_ALUResult,
    input  logic [15:0] EXMEM_read2DataOut,
    input  logic [15:0] mem_rdata,
    input  logic        mem_done,
    output logic        mem_en,
    output logic        mem_wr,
    output logic [15:0] mem_addr,
    output logic [15:0] mem_wdata,
    output logic        Stall_DM,
    output logic [15:0] dm_rdata,
    output logic        err
`ifdef DMEM_PERF_CNT_EN
    ,
    output logic [15:0] stall_cycles
`endif
);

    localparam int unsigned DATA_W = 16;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_ERR  = 2'd2
    } state_t;

    state_t              r_state;
    logic [CNT_W-1:0]    r_cnt;
    logic [DATA_W-1:0]   r_rdata_q;

    logic w_memop;
    logic w_illegal;
    logic w_timeout;
    logic w_en;
    logic w_stall;
    logic w_rd_done;

    assign w_memop   = EXMEM_IDEX_MemRead | EXMEM_IDEX_MemWrite;
    assign w_illegal = (EXMEM_IDEX_MemRead & EXMEM_IDEX_MemWrite) | (w_memop & EXMEM_ALUResult[0]);
    assign w_timeout = (r_cnt == CNT_W'(TIMEOUT)) & ~mem_done;

    // Request/stall decode; reset forces both low immediately so nothing is held across it
    always_comb begin
        w_en    = 1'b0;
        w_stall = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_memop && !EXMEM_IDEX_HALT && !w_illegal) begin
                    w_en    = 1'b1;
                    w_stall = ~mem_done;
                end
            end
            S_BUSY: begin
                if (w_memop && !w_timeout) begin
                    w_en    = 1'b1;
                    w_stall = ~mem_done;
                end
            end
            default: begin
                w_en    = 1'b0;
                w_stall = 1'b0;
            end
        endcase
        if (!rst) begin
            w_en    = 1'b0;
            w_stall = 1'b0;
        end
    end

    assign w_rd_done = w_en & mem_done & ~EXMEM_IDEX_MemWrite;

    assign mem_en    = w_en;
    assign mem_wr    = w_en & EXMEM_IDEX_MemWrite;
    assign mem_addr  = w_memop ? EXMEM_ALUResult : '0;
    assign mem_wdata = w_memop ? EXMEM_read2DataOut : '0;
    assign Stall_DM  = w_stall;
    assign dm_rdata  = w_rd_done ? mem_rdata : r_rdata_q;
    assign err       = (r_state == S_ERR);

    // Access FSM, timeout counter and last-load-data capture
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            r_rdata_q <= '0;
        end else begin
            if (w_rd_done) begin
                r_rdata_q <= mem_rdata;
            end
            case (r_state)
                S_IDLE: begin
                    // halt wins over both a legal and an illegal access
                    if (w_memop && !EXMEM_IDEX_HALT) begin
                        if (w_illegal) begin
                            r_state <= S_ERR;
                        end else if (!mem_done) begin
                            r_state <= S_BUSY;
                            r_cnt   <= CNT_W'(1);
                        end
                    end
                end
                S_BUSY: begin
                    if (!w_memop || mem_done) begin
                        r_state <= S_IDLE;
                        r_cnt   <= '0;
                    end else if (w_timeout) begin
                        r_state <= S_ERR;
                        r_cnt   <= '0;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                S_ERR: begin
                    r_state <= S_ERR;
                end
                default: begin
                    r_state <= S_IDLE;
                    r_cnt   <= '0;
                end
            endcase
        end
    end

`ifdef DMEM_PERF_CNT_EN
    logic [15:0] r_stall_cycles;

    // Saturating count of clock edges spent with the pipeline stalled
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_stall_cycles <= '0;
        end else if (w_stall && (r_stall_cycles != 16'hFFFF)) begin
            r_stall_cycles <= r_stall_cycles + 16'd1;
        end
    end

    assign stall_cycles = r_stall_cycles;
`endif

endmodule

// File: tb/tb_dmem_access_ctrl.sv
// Bench for dmem_access_ctrl: directed scenarios followed by random traffic,
// all checked against an access-age reference model of the memory protocol.
module tb_dmem_access_ctrl;

    localparam int unsigned TO = 8;
    localparam int unsigned CW = 4;

    logic        clk;
    logic        rst;
    logic        rd, wr, hl;
    logic [15:0] addr, wdata, rdata_in;
    logic        done;
    logic        mem_en, mem_wr, Stall_DM, err;
    logic [15:0] mem_addr, mem_wdata, dm_rdata;
`ifdef DMEM_PERF_CNT_EN
    logic [15:0] stall_cycles;
`endif

    dmem_access_ctrl #(.TIMEOUT(TO), .CNT_W(CW)) dut (
        .clk                 (clk),
        .rst                 (rst),
        .EXMEM_IDEX_MemRead  (rd),
        .EXMEM_IDEX_MemWrite (wr),
        .EXMEM_IDEX_HALT     (hl),
        .EXMEM_ALUResult     (addr),
        .EXMEM_read2DataOut  (wdata),
        .mem_rdata           (rdata_in),
        .mem_done            (done),
        .mem_en              (mem_en),
        .mem_wr              (mem_wr),
        .mem_addr            (mem_addr),
        .mem_wdata           (mem_wdata),
        .Stall_DM            (Stall_DM),
        .dm_rdata            (dm_rdata),
        .err                 (err)
`ifdef DMEM_PERF_CNT_EN
        ,
        .stall_cycles        (stall_cycles)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // reference model: age of outstanding access (0 = none), sticky error, last load, stall count
    int          m_age  = 0;
    bit          m_err  = 0;
    logic [15:0] m_rq   = 16'h0;
    int          m_perf = 0;
    bit          last_stall = 0;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // one clock cycle: drive at negedge, check settled outputs, advance the model for the next edge
    task automatic cyc(input logic i_rd, input logic i_wr, input logic i_hl,
                       input logic [15:0] i_a, input logic [15:0] i_wd,
                       input logic i_dn, input logic [15:0] i_rdv, input logic i_rv);
        bit memop, ill, go_err, e_en, e_stall, e_wr, rd_done;
        logic [15:0] e_rdata;
        @(negedge clk);
        rd = i_rd; wr = i_wr; hl = i_hl; addr = i_a; wdata = i_wd;
        done = i_dn; rdata_in = i_rdv; rst = i_rv;
        #1;
        if (!i_rv) begin
            m_age = 0; m_err = 0; m_rq = 16'h0; m_perf = 0;
        end
        memop   = i_rd | i_wr;
        ill     = (i_rd & i_wr) | (memop & i_a[0]);
        go_err  = 0;
        e_en    = 0;
        e_stall = 0;
        if (i_rv && !m_err && memop) begin
            if (m_age == 0) begin
                if (i_hl) begin
                    e_en = 0;
                end else if (ill) begin
                    go_err = 1;
                end else begin
                    e_en = 1; e_stall = !i_dn;
                end
            end else if (m_age == int'(TO) && !i_dn) begin
                go_err = 1;
            end else begin
                e_en = 1; e_stall = !i_dn;
            end
        end
        e_wr    = e_en & i_wr;
        rd_done = e_en & i_dn & !i_wr;
        e_rdata = rd_done ? i_rdv : m_rq;

        chk("mem_en",    16'(mem_en),   16'(e_en));
        chk("mem_wr",    16'(mem_wr),   16'(e_wr));
        chk("Stall_DM",  16'(Stall_DM), 16'(e_stall));
        chk("err",       16'(err),      16'(m_err));
        chk("dm_rdata",  dm_rdata,      e_rdata);
        if (e_en) begin
            chk("mem_addr",  mem_addr,  i_a);
            chk("mem_wdata", mem_wdata, i_wd);
        end
`ifdef DMEM_PERF_CNT_EN
        chk("stall_cycles", stall_cycles, 16'(m_perf));
`endif
        last_stall = e_stall;
        if (i_rv) begin
            if (rd_done) m_rq = i_rdv;
            if (go_err) begin
                m_err = 1; m_age = 0;
            end else if (e_en) begin
                m_age = i_dn ? 0 : m_age + 1;
            end else begin
                m_age = 0;
            end
            if (e_stall && m_perf < 65535) m_perf++;
        end
    endtask

    task automatic idle(input logic i_rv);
        cyc(0, 0, 0, 16'h0, 16'h0, 0, 16'h0, i_rv);
    endtask

    initial begin
        int perf0;
        rst = 1'b0; rd = 0; wr = 0; hl = 0; addr = '0; wdata = '0; done = 0; rdata_in = '0;

        // reset state
        idle(0); idle(0);
        idle(1);
        chk("rst_dm_rdata", dm_rdata, 16'h0000);

        // zero-stall read
        cyc(1, 0, 0, 16'h0010, 16'h0, 1, 16'hBEEF, 1);
        chk("zs_rdata", dm_rdata, 16'hBEEF);
        chk("zs_stall", 16'(Stall_DM), 16'h0);
        idle(1);
        chk("zs_hold", dm_rdata, 16'hBEEF);

        // write completing on the third cycle
        perf0 = m_perf;
        cyc(0, 1, 0, 16'h0020, 16'h1234, 0, 16'h0, 1);
        cyc(0, 1, 0, 16'h0020, 16'h1234, 0, 16'h0, 1);
        chk("wr_stall2", 16'(Stall_DM), 16'h1);
        cyc(0, 1, 0, 16'h0020, 16'h1234, 1, 16'h0, 1);
        chk("wr_wdata", mem_wdata, 16'h1234);
        chk("wr_stall3", 16'(Stall_DM), 16'h0);
        idle(1);
        chk("wr_perf_delta", 16'(m_perf - perf0), 16'd2);

        // read done after 2 cycles, then write done immediately, no dead cycle
        cyc(1, 0, 0, 16'h0040, 16'h0, 0, 16'h0, 1);
        cyc(1, 0, 0, 16'h0040, 16'h0, 1, 16'hCAFE, 1);
        cyc(0, 1, 0, 16'h0042, 16'h5555, 1, 16'h0, 1);
        chk("b2b_en", 16'(mem_en), 16'h1);
        chk("b2b_rdata_hold", dm_rdata, 16'hCAFE);
        idle(1);

        // hung read: 8 stall cycles, abort, sticky error
        for (int i = 0; i < int'(TO) + 1; i++) cyc(1, 0, 0, 16'h0060, 16'h0, 0, 16'h0, 1);
        chk("to_stall_off", 16'(Stall_DM), 16'h0);
        idle(1);
        chk("to_err", 16'(err), 16'h1);
        cyc(0, 1, 0, 16'h0062, 16'h7777, 1, 16'h0, 1);
        chk("to_no_req", 16'(mem_en), 16'h0);
        idle(0); idle(1);

        // unaligned read
        cyc(1, 0, 0, 16'h0003, 16'h0, 1, 16'h1111, 1);
        idle(1);
        chk("unal_err", 16'(err), 16'h1);
        idle(0); idle(1);

        // read and write together
        cyc(1, 1, 0, 16'h0004, 16'h0, 1, 16'h0, 1);
        idle(1);
        chk("rw_err", 16'(err), 16'h1);
        idle(0); idle(1);

        // halt drops the access
        cyc(1, 0, 1, 16'h0008, 16'h0, 0, 16'h0, 1);
        chk("halt_no_req", 16'(mem_en), 16'h0);
        idle(1);

        // reset during BUSY
        cyc(1, 0, 0, 16'h0080, 16'h0, 0, 16'h0, 1);
        cyc(1, 0, 0, 16'h0080, 16'h0, 0, 16'h0, 1);
        cyc(1, 0, 0, 16'h0080, 16'h0, 0, 16'h0, 0);
        chk("rstb_en", 16'(mem_en), 16'h0);
        idle(1);
        chk("rstb_err", 16'(err), 16'h0);
        chk("rstb_addr", mem_addr, 16'h0);

        // random traffic; instruction held while the model says the pipeline is stalled
        begin
            logic r_rd = 0, r_wr = 0, r_hl = 0;
            logic [15:0] r_a = '0, r_wd = '0;
            for (int i = 0; i < 600; i++) begin
                logic rv;
                if (!last_stall) begin
                    int op;
                    op   = int'($urandom_range(19));
                    r_rd = (op >= 6 && op <= 11) || op == 18 || op == 19;
                    r_wr = (op >= 12 && op <= 18);
                    r_hl = (op == 19);
                    r_a  = 16'($urandom) & 16'hFFFE;
                    if ($urandom_range(19) == 0) r_a = r_a | 16'h0001;
                    r_wd = 16'($urandom);
                end
                rv = !((m_err && $urandom_range(2) == 0) || $urandom_range(99) == 0);
                cyc(r_rd, r_wr, r_hl, r_a, r_wd, $urandom_range(2) == 0, 16'($urandom), rv);
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
